// File: rtl/interval_pkg.sv
// Shared types and defaults for the interval search controller.
// FP16 scalars, FSM states and sizing defaults.
package interval_pkg;

  // fpnew_pkg::fp_format_e encoding for FP16
  localparam logic [2:0] FpFormat = 3'd2;
  localparam int WIDTH = 16;

  localparam int NUM_DEF = 8;
  localparam int LOG2N_DEF = $clog2(NUM_DEF);

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DONE
  } state_e;

  typedef logic [WIDTH-1:0] fp_t;

endpackage

// File: rtl/interval_fp_le.sv
// Combinational FP16 a <= b compare.
// NaN on either side gives false; +0 and -0 compare equal.
module interval_fp_le
  import interval_pkg::*;
(
  input  fp_t  a_i,
  input  fp_t  b_i,
  output logic le_o
);

  logic a_nan;
  logic b_nan;
  logic both_zero;
  logic mag_le;
  logic mag_ge;

  assign a_nan = (&a_i[14:10]) & (|a_i[9:0]);
  assign b_nan = (&b_i[14:10]) & (|b_i[9:0]);
  assign both_zero = ~(|a_i[14:0]) & ~(|b_i[14:0]);
  assign mag_le = a_i[14:0] <= b_i[14:0];
  assign mag_ge = a_i[14:0] >= b_i[14:0];

  // sign-magnitude: negative magnitudes order in reverse
  always_comb begin
    le_o = 1'b0;
    if (a_nan || b_nan) begin
      le_o = 1'b0;
    end else if (both_zero) begin
      le_o = 1'b1;
    end else if (a_i[15] != b_i[15]) begin
      le_o = a_i[15];
    end else if (a_i[15]) begin
      le_o = mag_ge;
    end else begin
      le_o = mag_le;
    end
  end

endmodule

// File: rtl/interval_search_ctrl.sv
// Binary-search interval classifier sharing one FP16 comparator.
// Define INTERVAL_HIST_EN to add per-interval saturating hit counters.
module interval_search_ctrl
  import interval_pkg::*;
#(
  parameter int NUM = NUM_DEF
`ifdef INTERVAL_HIST_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     cfg_we_i,
  input  logic [$clog2(NUM)-1:0]   cfg_addr_i,
  input  fp_t                      cfg_data_i,
  output logic                     cfg_ready_o,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  fp_t                      in_data_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [NUM-1:0]           out_interval_o,
  output logic [$clog2(NUM)-1:0]   out_index_o
`ifdef INTERVAL_HIST_EN
  ,
  input  logic                     hist_clr_i,
  input  logic [$clog2(NUM)-1:0]   hist_sel_i,
  output logic [CNT_W-1:0]         hist_cnt_o
`endif
);

  localparam int LOG2N = $clog2(NUM);
  typedef logic [LOG2N-1:0] idx_t;

  state_e state_q;
  state_e state_d;

  fp_t  tbl_q [NUM];
  fp_t  s_q;
  idx_t k_q;
  idx_t step_q;
  idx_t cand;
  idx_t probe;
  logic le;
  logic in_hs;
  logic cfg_hs;

  assign cand  = k_q | (idx_t'(1) << step_q);
  assign probe = cand - idx_t'(1);

  interval_fp_le u_le (
    .a_i  (tbl_q[probe]),
    .b_i  (s_q),
    .le_o (le)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid_i) state_d = SEARCH;
      SEARCH:  if (step_q == '0) state_d = DONE;
      DONE:    if (out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready_o  = 1'b0;
    cfg_ready_o = 1'b0;
    out_valid_o = 1'b0;
    out_index_o = '0;
    unique case (state_q)
      IDLE: begin
        in_ready_o  = 1'b1;
        cfg_ready_o = 1'b1;
      end
      DONE: begin
        out_valid_o = 1'b1;
        out_index_o = k_q;
      end
      default: ;
    endcase
  end

  assign out_interval_o = out_valid_o
    ? ({{(NUM-1){1'b0}}, 1'b1} << k_q)
    : '0;

  assign in_hs  = in_ready_o & in_valid_i;
  assign cfg_hs = cfg_ready_o & cfg_we_i
                & (cfg_addr_i < idx_t'(NUM-1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s_q    <= '0;
      k_q    <= '0;
      step_q <= '0;
    end else if (in_hs) begin
      s_q    <= in_data_i;
      k_q    <= '0;
      step_q <= idx_t'(LOG2N-1);
    end else if (state_q == SEARCH) begin
      if (le) k_q <= cand;
      step_q <= step_q - idx_t'(1);
    end
  end

  // top slot is never written and never probed
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM; i++) tbl_q[i] <= '0;
    end else if (cfg_hs) begin
      tbl_q[cfg_addr_i] <= cfg_data_i;
    end
  end

`ifdef INTERVAL_HIST_EN
  logic [CNT_W-1:0] hist_q [NUM];
  logic             out_hs;

  assign out_hs = out_valid_o & out_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i || hist_clr_i) begin
      for (int i = 0; i < NUM; i++) hist_q[i] <= '0;
    end else if (out_hs && (hist_q[k_q] != '1)) begin
      hist_q[k_q] <= hist_q[k_q] + CNT_W'(1);
    end
  end

  assign hist_cnt_o = hist_q[hist_sel_i];
`endif

endmodule

// File: tb/tb_interval_search_ctrl.sv
// Randomized bench for interval_search_ctrl with a real-valued model.
// Build with INTERVAL_HIST_EN to also exercise the counters.
module tb_interval_search_ctrl;
  import interval_pkg::*;

  localparam int NUM = 8;
  localparam int LOG2N = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_addr = '0;
  logic [15:0] cfg_data = '0;
  logic        cfg_ready_o;
  logic        in_valid = 1'b0;
  logic        in_ready_o;
  logic [15:0] in_data = '0;
  logic        out_valid_o;
  logic        out_ready = 1'b0;
  logic [7:0]  out_interval_o;
  logic [2:0]  out_index_o;
`ifdef INTERVAL_HIST_EN
  logic        hist_clr = 1'b0;
  logic [2:0]  hist_sel = '0;
  logic [15:0] hist_cnt_o;
`endif

  int vectors = 0;
  int miscompares = 0;
  int exp_k = 0;
  logic [15:0] mtab [NUM-1];

  always #5 clk = ~clk;

  interval_search_ctrl #(.NUM(NUM)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .cfg_we_i       (cfg_we),
    .cfg_addr_i     (cfg_addr),
    .cfg_data_i     (cfg_data),
    .cfg_ready_o    (cfg_ready_o),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready_o),
    .in_data_i      (in_data),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready),
    .out_interval_o (out_interval_o),
    .out_index_o    (out_index_o)
`ifdef INTERVAL_HIST_EN
    ,
    .hist_clr_i     (hist_clr),
    .hist_sel_i     (hist_sel),
    .hist_cnt_o     (hist_cnt_o)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic bit is_nan(input logic [15:0] h);
    return (h[14:10] == 5'h1f) && (h[9:0] != 10'h0);
  endfunction

  function automatic real tor(input logic [15:0] h);
    int  e;
    real m;
    e = int'(h[14:10]);
    if (e == 31) begin
      m = 1.0e30;
    end else begin
      m = real'(h[9:0]);
      if (e == 0) e = 1;
      else m = m + 1024.0;
      for (int i = 0; i < 25 - e; i++) m = m / 2.0;
      for (int i = 0; i < e - 25; i++) m = m * 2.0;
    end
    if (h[15]) m = -m;
    return m;
  endfunction

  function automatic bit fle(input logic [15:0] a, input logic [15:0] b);
    if (is_nan(a) || is_nan(b)) return 1'b0;
    return tor(a) <= tor(b);
  endfunction

  function automatic int model_k(input logic [15:0] s);
    int k;
    int cand;
    k = 0;
    for (int b = LOG2N - 1; b >= 0; b--) begin
      cand = k + (1 << b);
      if (fle(mtab[cand-1], s)) k = cand;
    end
    return k;
  endfunction

  function automatic logic [15:0] rnd_fp();
    logic [15:0] sp [8];
    sp = '{16'h0000, 16'h8000, 16'h7c00, 16'hfc00,
           16'h7e00, 16'h3c00, 16'hbc00, 16'h0001};
    if ($urandom_range(3) == 0) return sp[$urandom_range(7)];
    return 16'($urandom);
  endfunction

  // every cycle: output is either the modelled result or all zero
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid_o) begin
        chk("out_index", 32'(out_index_o), exp_k);
        chk("out_interval", 32'(out_interval_o), 1 << exp_k);
      end else begin
        chk("idle_index", 32'(out_index_o), 0);
        chk("idle_interval", 32'(out_interval_o), 0);
      end
    end
  end

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    chk("cfg_ready", 32'(cfg_ready_o), 1);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    if (a < 3'd7) mtab[a] = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic xfer(input logic [15:0] s, input int want, input int hold,
                      input bit same_wr, input bit srch_wr,
                      input logic [2:0] wa, input logic [15:0] wd,
                      input bit mid_rst);
    int lat;
    int k;
    @(negedge clk);
    chk("in_ready", 32'(in_ready_o), 1);
    in_valid = 1'b1;
    in_data = s;
    if (same_wr) begin
      cfg_we = 1'b1;
      cfg_addr = wa;
      cfg_data = wd;
      if (wa < 3'd7) mtab[wa] = wd;
    end
    @(negedge clk);
    in_valid = 1'b0;
    cfg_we = 1'b0;
    k = model_k(s);
    if (want >= 0) chk("model_pin", k, want);
    exp_k = k;
    if (srch_wr) begin
      chk("cfg_ready_search", 32'(cfg_ready_o), 0);
      cfg_we = 1'b1;
      cfg_addr = wa;
      cfg_data = wd;
    end
    if (mid_rst) begin
      @(negedge clk);
      cfg_we = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_out_valid", 32'(out_valid_o), 0);
      chk("rst_in_ready", 32'(in_ready_o), 1);
      chk("rst_cfg_ready", 32'(cfg_ready_o), 1);
      for (int i = 0; i < NUM - 1; i++) mtab[i] = 16'h0000;
      return;
    end
    lat = 1;
    while (!out_valid_o && lat < 20) begin
      @(negedge clk);
      cfg_we = 1'b0;
      lat++;
    end
    chk("latency", lat, LOG2N + 1);
    if (hold > 0) begin
      in_valid = 1'b1;
      in_data = rnd_fp();
    end
    for (int i = 0; i < hold; i++) begin
      chk("hold_in_ready", 32'(in_ready_o), 0);
      chk("hold_out_valid", 32'(out_valid_o), 1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("post_in_ready", 32'(in_ready_o), 1);
    chk("post_out_valid", 32'(out_valid_o), 0);
  endtask

  task automatic load_std();
    logic [15:0] t [7];
    t = '{16'hc400, 16'hc000, 16'hbc00, 16'h0000,
          16'h3c00, 16'h4000, 16'h4400};
    for (int i = 0; i < 7; i++) wr(3'(i), t[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: run exceeded time budget");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NUM - 1; i++) mtab[i] = 16'h0000;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", 32'(in_ready_o), 1);
    chk("reset_cfg_ready", 32'(cfg_ready_o), 1);
    chk("reset_out_valid", 32'(out_valid_o), 0);
    chk("reset_interval", 32'(out_interval_o), 0);
    rst = 1'b0;

    xfer(16'h3c00, 7, 0, 0, 0, 0, 0, 0);
    load_std();
    xfer(16'h3e00, 5, 0, 0, 0, 0, 0, 0);
    xfer(16'hc500, 0, 0, 0, 0, 0, 0, 0);
    xfer(16'h4400, 7, 1, 0, 0, 0, 0, 0);
    xfer(16'h7e00, 0, 0, 0, 0, 0, 0, 0);
    xfer(16'h8000, 4, 0, 0, 0, 0, 0, 0);
    xfer(16'h3e00, 5, 5, 0, 0, 0, 0, 0);

    xfer(16'h3a00, 4, 0, 0, 1, 3'd4, 16'hc400, 0);
    xfer(16'h3a00, 4, 0, 0, 0, 0, 0, 0);
    wr(3'd7, 16'hc400);
    xfer(16'h4400, 7, 0, 0, 0, 0, 0, 0);
    xfer(16'h3a00, 5, 0, 1, 0, 3'd4, 16'h3800, 0);

    xfer(16'h3c00, -1, 0, 0, 0, 0, 0, 1);
    xfer(16'h3c00, 7, 0, 0, 0, 0, 0, 0);

    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(2) == 0)
        wr(3'($urandom_range(7)), rnd_fp());
      xfer(rnd_fp(), -1, $urandom_range(2),
           ($urandom_range(7) == 0), 0,
           3'($urandom_range(7)), rnd_fp(), 0);
    end

`ifdef INTERVAL_HIST_EN
    load_std();
    @(negedge clk);
    hist_clr = 1'b1;
    @(negedge clk);
    hist_clr = 1'b0;
    repeat (3) xfer(16'h3e00, 5, 0, 0, 0, 0, 0, 0);
    hist_sel = 3'd5;
    @(negedge clk);
    chk("hist_cnt5", 32'(hist_cnt_o), 3);
    hist_sel = 3'd0;
    @(negedge clk);
    chk("hist_cnt0", 32'(hist_cnt_o), 0);
    hist_clr = 1'b1;
    @(negedge clk);
    hist_clr = 1'b0;
    hist_sel = 3'd5;
    @(negedge clk);
    chk("hist_clr", 32'(hist_cnt_o), 0);
`endif

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
